// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-detecting, maskable, fixed-priority interrupt controller feeding the risc core INT input
// Ports: clk; rst async active-low; irq raw lines; mask_we/mask_wdata mask register write (1 = enabled);
//        ack/eoi core handshake pulses; INT request to core; irq_id requested/in-service line; pending latched requests.
// Optional: define IRQ_SYNC_EN to add a two-flop synchronizer on every irq line (two extra cycles of latency).
module irq_ctrl #(
    parameter int N_IRQ = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             ack,
    input  logic             eoi,
    output logic             INT,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_IRQ-1:0] pending
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t state, state_n;
    logic [N_IRQ-1:0] mask, prev, smp, edg, elig, clr;
    logic [ID_W-1:0] win, id_n;
`ifdef IRQ_SYNC_EN
    logic [N_IRQ-1:0] s1, s2;
    always_ff @(posedge clk or negedge rst)
        if (!rst) {s1, s2} <= '0;
        else {s1, s2} <= {irq, s1};
    assign smp = s2;
`else
    assign smp = irq;
`endif
    assign edg  = smp & ~prev;
    assign elig = pending & mask;
    // Only the line being acknowledged is cleared; a same-cycle edge re-sets it below.
    assign clr  = (state == REQ && ack) ? N_IRQ'(1) << irq_id : '0;
    // Scan downward so the lowest eligible index is the last to be written.
    always_comb begin
        win = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) if (elig[i]) win = ID_W'(i);
    end
    always_comb begin
        state_n = state;
        id_n    = irq_id;
        case (state)
            IDLE:    if (|elig) begin state_n = REQ; id_n = win; end
            REQ:     if (ack) state_n = SERVICE;
            SERVICE: if (eoi) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            INT     <= 1'b0;
            irq_id  <= '0;
            pending <= '0;
            mask    <= '0;
            prev    <= '0;
        end else begin
            state   <= state_n;
            INT     <= state_n == REQ;
            irq_id  <= id_n;
            pending <= (pending & ~clr) | edg;
            mask    <= mask_we ? mask_wdata : mask;
            prev    <= smp;
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: randomized + directed bench for irq_ctrl with a scoreboard of predicted grants
module tb_irq_ctrl;
    localparam int N = 4;
    localparam int W = 2;
`ifdef IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0] irq = '0;
    logic mask_we = 1'b0;
    logic [N-1:0] mask_wdata = '0;
    logic ack = 1'b0;
    logic eoi = 1'b0;
    logic INT;
    logic [W-1:0] irq_id;
    logic [N-1:0] pending;
    int checks = 0;
    int errors = 0;

    irq_ctrl #(.N_IRQ(N), .ID_W(W)) dut (
        .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .ack(ack), .eoi(eoi), .INT(INT), .irq_id(irq_id), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: history of irq samples, a set of pending lines, and a
    // phase (0 idle, 1 requesting, 2 in service). Grants go to the scoreboard.
    logic [N-1:0] h[$];
    logic [N-1:0] m_pend = '0, m_mask = '0, m_e, m_el;
    int m_ph = 0, m_id = 0, m_w;
    int exp_q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend = '0; m_mask = '0; m_ph = 0; m_id = 0;
            h = {};
            for (int i = 0; i < LAT + 2; i++) h.push_front('0);
            exp_q = {};
        end else begin
            h.push_front(irq);
            m_e = h[LAT] & ~h[LAT+1];
            void'(h.pop_back());
            m_el = m_pend & m_mask;
            m_w = -1;
            for (int i = 0; i < N; i++) if (m_el[i] && m_w < 0) m_w = i;
            if (m_ph == 1 && ack) m_pend[m_id] = 1'b0;
            m_pend = m_pend | m_e;
            if (m_ph == 0 && m_w >= 0) begin
                m_ph = 1; m_id = m_w; exp_q.push_back(m_w);
            end else if (m_ph == 1 && ack) m_ph = 2;
            else if (m_ph == 2 && eoi) m_ph = 0;
            if (mask_we) m_mask = mask_wdata;
        end
    end

    // Monitor: every rising INT consumes one predicted grant; state compared each cycle.
    logic int_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (INT && !int_prev) begin
                if (exp_q.size() == 0) chk("grant_unexpected", int'(irq_id), -1);
                else chk("grant_id", int'(irq_id), exp_q.pop_front());
            end
            chk("int", int'(INT), int'(m_ph == 1));
            chk("id", int'(irq_id), m_id);
            chk("pending", int'(pending), int'(m_pend));
        end
        int_prev = rst ? INT : 1'b0;
    end

    task automatic set_mask(input logic [N-1:0] m);
        @(negedge clk); mask_we = 1'b1; mask_wdata = m;
        @(negedge clk); mask_we = 1'b0;
    endtask
    task automatic pulse_irq(input int i);
        @(negedge clk); irq[i] = 1'b1;
        @(negedge clk); irq[i] = 1'b0;
    endtask
    task automatic do_ack();
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
    endtask
    task automatic do_eoi();
        @(negedge clk); eoi = 1'b1;
        @(negedge clk); eoi = 1'b0;
    endtask
    task automatic wait_int();
        int n = 0;
        while (!INT && n < 50) begin @(negedge clk); n++; end
        chk("int_wait", int'(INT), 1);
    endtask

    initial begin
        int n;
        irq = '1;
        repeat (2) @(negedge clk);
        chk("rst_int", int'(INT), 0);
        chk("rst_id", int'(irq_id), 0);
        chk("rst_pend", int'(pending), 0);
        rst = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        chk("masked_pend", int'(pending), 15);
        chk("masked_int", int'(INT), 0);
        irq = '0; rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        // single request and latency
        set_mask(4'hF);
        irq[2] = 1'b1;
        n = 0;
        while (!INT && n < 20) begin @(posedge clk); #1; n++; end
        chk("latency", n, LAT + 2);
        chk("single_id", int'(irq_id), 2);
        irq[2] = 1'b0;
        do_ack();
        chk("ack_int", int'(INT), 0);
        chk("ack_pend2", int'(pending[2]), 0);
        do_eoi();
        // no preemption
        pulse_irq(3);
        wait_int();
        pulse_irq(1);
        repeat (LAT + 3) @(negedge clk);
        chk("nopreempt_id", int'(irq_id), 3);
        chk("nopreempt_pend", int'(pending), 4'b1010);
        do_ack(); do_eoi();
        wait_int();
        chk("prio_id", int'(irq_id), 1);
        do_ack(); do_eoi();
        // masked line latches but is not selected until unmasked
        set_mask(4'b1110);
        pulse_irq(0);
        repeat (LAT + 3) @(negedge clk);
        chk("mask_pend0", int'(pending[0]), 1);
        chk("mask_int", int'(INT), 0);
        set_mask(4'hF);
        @(posedge clk); #1;
        chk("unmask_int", int'(INT), 1);
        chk("unmask_id", int'(irq_id), 0);
        do_ack(); do_eoi();
        // edge on line 1 arriving at the same edge as its ack
        pulse_irq(1);
        wait_int();
        @(negedge clk); irq[1] = 1'b1;
        repeat (LAT) @(negedge clk);
        ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        chk("collide_pend1", int'(pending[1]), 1);
        chk("collide_int", int'(INT), 0);
        do_eoi();
        wait_int();
        chk("rereq_id", int'(irq_id), 1);
        do_ack(); do_eoi();
        repeat (LAT + 4) @(negedge clk);
        chk("held_int", int'(INT), 0);
        chk("held_pend", int'(pending), 0);
        irq = '0;
        // async reset in SERVICE
        pulse_irq(3);
        wait_int();
        do_ack();
        pulse_irq(0);
        repeat (LAT + 2) @(negedge clk);
        chk("pre_rst_id", int'(irq_id), 3);
        chk("pre_rst_pend", int'(pending), 1);
        @(posedge clk); #2 rst = 1'b0;
        #1;
        chk("arst_int", int'(INT), 0);
        chk("arst_id", int'(irq_id), 0);
        chk("arst_pend", int'(pending), 0);
        @(negedge clk); rst = 1'b1;
        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) irq = irq ^ (N'(1) << $urandom_range(N - 1));
            ack = $urandom_range(2) == 0;
            eoi = $urandom_range(2) == 0;
            mask_we = $urandom_range(15) == 0;
            mask_wdata = N'($urandom);
            if (c == 1500) begin #2 rst = 1'b0; #2 rst = 1'b1; end
        end
        @(negedge clk);
        irq = '0; ack = 1'b0; eoi = 1'b0; mask_we = 1'b0;
        @(negedge clk); #1;
        chk("q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
